// File: rtl/loteria_param.sv
// loteria_param: parametrised lottery-ticket checker.
// Collects DIGITS BCD digits with backspace editing. On finish it scores the
// ticket by the longest run of consecutive position matches against SECRET.
// Optional build macro LOTERIA_SEG_OUT_EN adds the registered, active-low
// seven-segment outputs seg_o / seg_prize_o (gfedcba).
module loteria_param #(
    parameter int          DIGITS = 5,
    parameter logic [31:0] SECRET = 32'h00050967,
    localparam int         CW     = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            digit_in,
    input  logic                  insert,
    input  logic                  backspace,
    input  logic                  finish,
    input  logic                  new_game,
    output logic [4*DIGITS-1:0]   digits_o,
    output logic [CW-1:0]         count_o,
    output logic [1:0]            state_o,
    output logic [DIGITS-1:0]     match_o,
    output logic [1:0]            prize_o,
    output logic                  win_o,
    output logic                  done_o,
    output logic                  err_o
`ifdef LOTERIA_SEG_OUT_EN
    ,
    output logic [7*DIGITS-1:0]   seg_o,
    output logic [6:0]            seg_prize_o
`endif
);

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        READY  = 2'd1,
        EVAL   = 2'd2,
        RESULT = 2'd3
    } state_t;

    // Run-length thresholds for each prize tier, in counter-width arithmetic
    localparam logic [CW-1:0] L_TIER3 = CW'(DIGITS);
    localparam logic [CW-1:0] L_TIER2 = CW'(DIGITS - 1);
    localparam logic [CW-1:0] L_TIER1 = CW'(DIGITS - 2);

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   digits_q, digits_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DIGITS-1:0]     match_q, match_d;
    logic [1:0]            prize_q, prize_d;
    logic                  win_q, win_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [1:0]            cmd_cnt;
    logic                  multi_cmd;
    logic                  any_cmd;
    logic [CW-1:0]         run_len;

    // Longest run of consecutive ones in the match vector
    function automatic logic [CW-1:0] longest_run(input logic [DIGITS-1:0] m);
        logic [CW-1:0] run;
        logic [CW-1:0] best;
        run  = '0;
        best = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (m[i]) run = run + 1'b1;
            else      run = '0;
            if (run > best) best = run;
        end
        return best;
    endfunction

    // Tier 1 would need a zero-length run when DIGITS==2, so it is suppressed
    function automatic logic [1:0] prize_of(input logic [CW-1:0] l);
        if (l == L_TIER3)                   return 2'd3;
        else if (l == L_TIER2)              return 2'd2;
        else if (DIGITS > 2 && l == L_TIER1) return 2'd1;
        else                                return 2'd0;
    endfunction

    assign cmd_cnt   = {1'b0, insert} + {1'b0, backspace} + {1'b0, finish};
    assign multi_cmd = (cmd_cnt > 2'd1);
    assign any_cmd   = (cmd_cnt != 2'd0);
    assign run_len   = longest_run(match_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ENTRY;
        else       state_q <= state_d;
    end

    // Next-state logic; EVAL always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = ENTRY;
        end else if (state_q == EVAL) begin
            state_d = RESULT;
        end else if (!multi_cmd) begin
            case (state_q)
                ENTRY:   if (insert && digit_in <= 4'd9 && count_q == L_TIER2) state_d = READY;
                READY:   if (backspace)   state_d = ENTRY;
                         else if (finish) state_d = EVAL;
                default: ;
            endcase
        end
    end

    // Next values of all registered outputs
    always_comb begin
        digits_d = digits_q;
        count_d  = count_q;
        match_d  = match_q;
        prize_d  = prize_q;
        win_d    = win_q;
        err_d    = 1'b0;
        if (new_game) begin
            digits_d = '0;
            count_d  = '0;
            match_d  = '0;
            prize_d  = '0;
            win_d    = 1'b0;
        end else begin
            if (state_q == EVAL) begin
                prize_d = prize_of(run_len);
                win_d   = (prize_d != 2'd0);
            end
            if (multi_cmd) begin
                err_d = 1'b1;
            end else begin
                case (state_q)
                    ENTRY, READY: begin
                        if (insert) begin
                            if (state_q == READY || digit_in > 4'd9) begin
                                err_d = 1'b1;
                            end else begin
                                for (int i = 0; i < DIGITS; i++) begin
                                    if (CW'(i) == count_q) begin
                                        digits_d[4*(DIGITS-1-i) +: 4] = digit_in;
                                        match_d[DIGITS-1-i] =
                                            (digit_in == SECRET[4*(DIGITS-1-i) +: 4]);
                                    end
                                end
                                count_d = count_q + 1'b1;
                            end
                        end else if (backspace) begin
                            if (count_q == '0) begin
                                err_d = 1'b1;
                            end else begin
                                for (int i = 0; i < DIGITS; i++) begin
                                    if (CW'(i + 1) == count_q) begin
                                        digits_d[4*(DIGITS-1-i) +: 4] = 4'd0;
                                        match_d[DIGITS-1-i] = 1'b0;
                                    end
                                end
                                count_d = count_q - 1'b1;
                            end
                        end else if (finish && state_q == ENTRY) begin
                            err_d = 1'b1;
                        end
                    end
                    RESULT:  if (any_cmd) err_d = 1'b1;
                    default: ;
                endcase
            end
        end
        done_d = (state_d == RESULT);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= '0;
            count_q  <= '0;
            match_q  <= '0;
            prize_q  <= '0;
            win_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            count_q  <= count_d;
            match_q  <= match_d;
            prize_q  <= prize_d;
            win_q    <= win_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign digits_o = digits_q;
    assign count_o  = count_q;
    assign state_o  = state_q;
    assign match_o  = match_q;
    assign prize_o  = prize_q;
    assign win_o    = win_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

`ifdef LOTERIA_SEG_OUT_EN
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Active-low gfedcba pattern for one BCD digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_DASH;
        endcase
    endfunction

    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic [6:0]          seg_prize_q, seg_prize_d;

    // Display patterns derived from the next-cycle ticket and prize
    always_comb begin
        seg_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg_d[7*(DIGITS-1-i) +: 7] = (CW'(i) < count_d) ?
                                         seg7(digits_d[4*(DIGITS-1-i) +: 4]) : SEG_DASH;
        end
        seg_prize_d = (state_d == RESULT) ? seg7({2'b00, prize_d}) : SEG_DASH;
    end

    // Display registers; an empty ticket shows dashes everywhere
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q       <= {DIGITS{SEG_DASH}};
            seg_prize_q <= SEG_DASH;
        end else begin
            seg_q       <= seg_d;
            seg_prize_q <= seg_prize_d;
        end
    end

    assign seg_o       = seg_q;
    assign seg_prize_o = seg_prize_q;
`endif

endmodule

// File: tb/tb_loteria_param.sv
// Directed bench for loteria_param: a DIGITS=5 default instance and a
// DIGITS=3 / SECRET=123 instance driven from the same command inputs.
module tb_loteria_param;

    logic        clk;
    logic        reset;
    logic [3:0]  digit_in;
    logic        insert, backspace, finish, new_game;

    logic [19:0] d5_digits;
    logic [2:0]  d5_count;
    logic [1:0]  d5_state;
    logic [4:0]  d5_match;
    logic [1:0]  d5_prize;
    logic        d5_win, d5_done, d5_err;

    logic [11:0] d3_digits;
    logic [1:0]  d3_count;
    logic [1:0]  d3_state;
    logic [2:0]  d3_match;
    logic [1:0]  d3_prize;
    logic        d3_win, d3_done, d3_err;

`ifdef LOTERIA_SEG_OUT_EN
    logic [34:0] d5_seg;
    logic [6:0]  d5_segp;
    logic [20:0] d3_seg;
    logic [6:0]  d3_segp;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    loteria_param u_dut5 (
        .clk(clk), .reset(reset), .digit_in(digit_in), .insert(insert),
        .backspace(backspace), .finish(finish), .new_game(new_game),
        .digits_o(d5_digits), .count_o(d5_count), .state_o(d5_state),
        .match_o(d5_match), .prize_o(d5_prize), .win_o(d5_win),
        .done_o(d5_done), .err_o(d5_err)
`ifdef LOTERIA_SEG_OUT_EN
        , .seg_o(d5_seg), .seg_prize_o(d5_segp)
`endif
    );

    loteria_param #(.DIGITS(3), .SECRET(32'h123)) u_dut3 (
        .clk(clk), .reset(reset), .digit_in(digit_in), .insert(insert),
        .backspace(backspace), .finish(finish), .new_game(new_game),
        .digits_o(d3_digits), .count_o(d3_count), .state_o(d3_state),
        .match_o(d3_match), .prize_o(d3_prize), .win_o(d3_win),
        .done_o(d3_done), .err_o(d3_err)
`ifdef LOTERIA_SEG_OUT_EN
        , .seg_o(d3_seg), .seg_prize_o(d3_segp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of commands; outputs are sampled 1ns after the edge
    task automatic step(input logic i, input logic b, input logic f,
                        input logic n, input logic [3:0] d);
        insert = i; backspace = b; finish = f; new_game = n; digit_in = d;
        @(posedge clk);
        #1;
        insert = 1'b0; backspace = 1'b0; finish = 1'b0; new_game = 1'b0;
        digit_in = 4'd0;
    endtask

    task automatic ins(input logic [3:0] d);  step(1'b1, 1'b0, 1'b0, 1'b0, d);    endtask
    task automatic bksp();                    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0); endtask
    task automatic fin();                     step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0); endtask
    task automatic idle();                    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0); endtask
    task automatic newg();                    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0); endtask

    task automatic ticket5(input logic [19:0] t);
        for (int k = 4; k >= 0; k--) ins(t[4*k +: 4]);
    endtask

    initial begin
        reset = 1'b1; digit_in = 4'd0;
        insert = 1'b0; backspace = 1'b0; finish = 1'b0; new_game = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset state
        chk("rst_state",  d5_state,  2'd0);
        chk("rst_digits", d5_digits, 20'h0);
        chk("rst_count",  d5_count,  3'd0);
        chk("rst_match",  d5_match,  5'b0);
        chk("rst_prize",  d5_prize,  2'd0);
        chk("rst_flags",  {d5_win, d5_done, d5_err}, 3'b000);

        // Exact ticket 50967
        ins(4'd5); ins(4'd0); ins(4'd9); ins(4'd6);
        chk("p3_count4",  d5_count, 3'd4);
        chk("p3_entry",   d5_state, 2'd0);
        ins(4'd7);
        chk("p3_ready",   d5_state, 2'd1);
        chk("p3_count5",  d5_count, 3'd5);
        chk("p3_digits",  d5_digits, 20'h50967);
        chk("p3_match",   d5_match, 5'b11111);
        fin();
        chk("p3_eval",    d5_state, 2'd2);
        chk("p3_eval_dn", d5_done, 1'b0);
        idle();
        chk("p3_result",  d5_state, 2'd3);
        chk("p3_prize",   d5_prize, 2'd3);
        chk("p3_win",     d5_win, 1'b1);
        chk("p3_done",    d5_done, 1'b1);
        ins(4'd1);
        chk("res_ins_err", d5_err, 1'b1);
        chk("res_hold",    {d5_state, d5_prize, d5_digits}, {2'd3, 2'd3, 20'h50967});

        // new_game in RESULT wins over a simultaneous insert, no error
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
        chk("ng_state", d5_state, 2'd0);
        chk("ng_clear", {d5_digits, d5_count, d5_match, d5_prize}, 30'h0);
        chk("ng_flags", {d5_win, d5_done, d5_err}, 3'b000);

        // 50961 -> run 4 -> prize 2
        ticket5(20'h50961); fin(); idle();
        chk("p2_match", d5_match, 5'b11110);
        chk("p2_prize", d5_prize, 2'd2);
        newg();

        // 10961 -> run 3 -> prize 1
        ticket5(20'h10961); fin(); idle();
        chk("p1_match", d5_match, 5'b01110);
        chk("p1_prize", {d5_prize, d5_win}, {2'd1, 1'b1});
        newg();

        // 50167 -> run 2 -> no prize
        ticket5(20'h50167); fin(); idle();
        chk("p0_match", d5_match, 5'b11011);
        chk("p0_prize", {d5_prize, d5_win, d5_done}, {2'd0, 1'b0, 1'b1});
        newg();

        // Editing and rejected commands
        bksp();
        chk("bk0_err",   d5_err, 1'b1);
        chk("bk0_count", d5_count, 3'd0);
        ins(4'd5); ins(4'd0); ins(4'd3);
        chk("ed_digits", d5_digits, 20'h50300);
        chk("ed_match",  d5_match, 5'b11000);
        bksp();
        chk("bk_count",  d5_count, 3'd2);
        chk("bk_digits", d5_digits, 20'h50000);
        chk("bk_err",    d5_err, 1'b0);
        ins(4'd12);
        chk("bad_err",    d5_err, 1'b1);
        chk("bad_count",  d5_count, 3'd2);
        chk("bad_digits", d5_digits, 20'h50000);
        idle();
        chk("err_pulse",  d5_err, 1'b0);
        fin();
        chk("fin_entry_err", {d5_err, d5_state}, {1'b1, 2'd0});
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
        chk("multi_err",    d5_err, 1'b1);
        chk("multi_nochg",  {d5_count, d5_digits, d5_state}, {3'd2, 20'h50000, 2'd0});
        ins(4'd9); ins(4'd6); ins(4'd7);
        chk("ed_ready",     d5_state, 2'd1);
        ins(4'd4);
        chk("rdy_ins_err",  {d5_err, d5_count, d5_digits}, {1'b1, 3'd5, 20'h50967});
        bksp();
        chk("rdy_bk",       {d5_state, d5_count, d5_digits, d5_match},
                            {2'd0, 3'd4, 20'h50960, 5'b11110});
        ins(4'd7); fin(); idle();
        chk("ed_prize",     {d5_state, d5_prize, d5_win}, {2'd3, 2'd3, 1'b1});
        newg();

        // Reset while in EVAL discards everything
        ticket5(20'h50967); fin();
        chk("pre_rst_eval", d5_state, 2'd2);
        reset = 1'b1; idle(); reset = 1'b0;
        chk("rst_eval_state", d5_state, 2'd0);
        chk("rst_eval_clear", {d5_digits, d5_count, d5_match, d5_prize}, 30'h0);
        chk("rst_eval_flags", {d5_win, d5_done, d5_err}, 3'b000);

        // DIGITS=3 instance, secret 123: ticket 124 -> run 2 -> prize 2
        ins(4'd1);
`ifdef LOTERIA_SEG_OUT_EN
        chk("seg3_one", d3_seg, {7'b1111001, 7'b0111111, 7'b0111111});
        chk("segp3_dash", d3_segp, 7'b0111111);
`endif
        ins(4'd2); ins(4'd4);
        chk("d3_ready",  {d3_state, d3_count, d3_digits}, {2'd1, 2'd3, 12'h124});
        chk("d3_match",  d3_match, 3'b110);
        fin(); idle();
        chk("d3_prize",  {d3_state, d3_prize, d3_win, d3_done}, {2'd3, 2'd2, 1'b1, 1'b1});
`ifdef LOTERIA_SEG_OUT_EN
        chk("seg3_full", d3_seg, {7'b1111001, 7'b0100100, 7'b0011001});
        chk("segp3_two", d3_segp, 7'b0100100);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
